// File: rtl/bind_command_dispatcher.sv
// Queues control-plane bind commands and issues them one at a time to the bind kernel mapper
// over the valid/done handshake; counts completions and flags mappers that never acknowledge.
module bind_command_dispatcher #(
   parameter int unsigned HV_ADDRESS_WIDTH = 20,
   parameter int unsigned FIFO_DEPTH       = 4,
   parameter int unsigned ACK_TIMEOUT      = 4,
   parameter int unsigned COUNT_WIDTH      = 16
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          cmd_valid,
   output logic                          cmd_ready,
   input  logic [HV_ADDRESS_WIDTH-1:0]   cmd_length,
   input  logic [HV_ADDRESS_WIDTH-1:0]   cmd_hva,
   input  logic [HV_ADDRESS_WIDTH-1:0]   cmd_hvb,
   input  logic [HV_ADDRESS_WIDTH-1:0]   cmd_hvc,
   output logic                          map_valid,
   output logic [HV_ADDRESS_WIDTH-1:0]   map_vec_length,
   output logic [HV_ADDRESS_WIDTH-1:0]   map_hva,
   output logic [HV_ADDRESS_WIDTH-1:0]   map_hvb,
   output logic [HV_ADDRESS_WIDTH-1:0]   map_hvc,
   input  logic                          map_done,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [COUNT_WIDTH-1:0]        ops_completed,
   output logic                          err_ack_timeout,
   input  logic                          err_clear
);

   localparam int unsigned AW    = HV_ADDRESS_WIDTH;
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

   typedef struct packed {
      logic [AW-1:0] length;
      logic [AW-1:0] hva;
      logic [AW-1:0] hvb;
      logic [AW-1:0] hvc;
   } cmd_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACK,
      S_RUN
   } state_t;

   state_t           state;
   state_t           state_nxt;
   cmd_t             mem [FIFO_DEPTH];
   cmd_t             cmd_in;
   cmd_t             head;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [LVL_W-1:0] level;
   logic [ACK_W-1:0] ack_cnt;
   logic [ACK_W-1:0] ack_cnt_nxt;
   logic             push;
   logic             pop;
   logic             issue;
   logic             complete;
   logic             timeout;

   assign cmd_in     = {cmd_length, cmd_hva, cmd_hvb, cmd_hvc};
   assign head       = mem[rd_ptr];
   assign cmd_ready  = (level != LVL_FULL);
   assign push       = cmd_valid && cmd_ready;
   assign fifo_level = level;
   assign busy       = (state != S_IDLE) || (level != '0);

   // Command FIFO; power-of-two depth lets the pointers wrap naturally.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr] <= cmd_in;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: ;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and per-cycle action strobes.
   always_comb begin
      state_nxt   = state;
      ack_cnt_nxt = ack_cnt;
      pop         = 1'b0;
      issue       = 1'b0;
      complete    = 1'b0;
      timeout     = 1'b0;
      case (state)
         S_IDLE: begin
            if ((level != '0) && map_done) begin
               pop = 1'b1;
               if (head.length == '0) begin
                  complete = 1'b1;
               end else begin
                  issue       = 1'b1;
                  ack_cnt_nxt = '0;
                  state_nxt   = S_ACK;
               end
            end
         end
         S_ACK: begin
            if (!map_done) begin
               state_nxt = S_RUN;
            end else if (ack_cnt == ACK_LAST) begin
               timeout   = 1'b1;
               state_nxt = S_IDLE;
            end else begin
               ack_cnt_nxt = ack_cnt + ACK_W'(1);
            end
         end
         S_RUN: begin
            if (map_done) begin
               complete  = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Mapper-facing registers, completion counter and sticky timeout flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         map_valid       <= 1'b0;
         map_vec_length  <= '0;
         map_hva         <= '0;
         map_hvb         <= '0;
         map_hvc         <= '0;
         ack_cnt         <= '0;
         ops_completed   <= '0;
         err_ack_timeout <= 1'b0;
      end else begin
         map_valid <= issue;
         ack_cnt   <= ack_cnt_nxt;
         if (issue) begin
            map_vec_length <= head.length;
            map_hva        <= head.hva;
            map_hvb        <= head.hvb;
            map_hvc        <= head.hvc;
         end
         if (complete) begin
            ops_completed <= ops_completed + COUNT_WIDTH'(1);
         end
         if (timeout) begin
            err_ack_timeout <= 1'b1;
         end else if (err_clear) begin
            err_ack_timeout <= 1'b0;
         end
      end
   end

endmodule
